keypad_matrix_emulator: RTL and testbench

Synthesizable model of a 4x4 membrane keypad: the far end of the keypad-scanner interface. It receives the scanner's column drive (C1:C0), and on request "presses" one key for a programmed time. For the pressed key it pulls the corresponding active-low row line (F0..F3) low whenever that key's column is scanned, including deterministic contact bounce at make and break. It lets scanner, debouncer and display paths be exercised on-board or in simulation without a physical keypad.

---
 rtl/keypad_pkg.sv | 27 ++
 rtl/keypad_contact_gen.sv | 52 +++++
 rtl/keypad_matrix_emulator.sv | 137 +++++++++++++
 tb/tb_keypad_matrix_emulator.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types, constants and key-code helpers for the keypad emulator
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  typedef logic [3:0] key_t;

  typedef enum logic [2:0] {
    IDLE,
    BOUNCE_IN,
    HOLD,
    BOUNCE_OUT,
    GAP
  } state_t;

  // Upper two bits of the key code select the row line
  function automatic logic [1:0] key_row(input key_t k);
    return k[3:2];
  endfunction

  // Lower two bits of the key code select the scanned column
  function automatic logic [1:0] key_col(input key_t k);
    return k[1:0];
  endfunction

endpackage

// File: rtl/keypad_contact_gen.sv
// rtl/keypad_contact_gen.sv - contact waveform generator with deterministic bounce
module keypad_contact_gen
  import keypad_pkg::*;
#(
  parameter int BOUNCE_LEN    = 2000,
  parameter int BOUNCE_PERIOD = 250
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic active,
  input  logic phase,
  input  logic level,
  output logic contact,
  output logic last
);

  localparam int BW = (BOUNCE_LEN > 0) ? $clog2(BOUNCE_LEN + 1) : 1;
  localparam int PW = $clog2(BOUNCE_PERIOD + 1);
  localparam logic [BW-1:0] B_LAST = BW'(BOUNCE_LEN - 1);
  localparam logic [PW-1:0] P_LAST = PW'(BOUNCE_PERIOD - 1);

  logic [BW-1:0] b_cnt;
  logic [PW-1:0] p_cnt;
  logic          tog;

  // Bounce length counter plus toggle sub-counter; tog starts at 1 on every bounce entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_cnt <= '0;
      p_cnt <= '0;
      tog   <= 1'b1;
    end else if (start) begin
      b_cnt <= '0;
      p_cnt <= '0;
      tog   <= 1'b1;
    end else if (active) begin
      b_cnt <= b_cnt + 1'b1;
      if (p_cnt == P_LAST) begin
        p_cnt <= '0;
        tog   <= ~tog;
      end else begin
        p_cnt <= p_cnt + 1'b1;
      end
    end
  end

  // Make bounce starts closed (phase=1), break bounce starts open (phase=0)
  assign contact = active ? (tog ~^ phase) : level;
  assign last    = active && (b_cnt == B_LAST);

endmodule

// File: rtl/keypad_matrix_emulator.sv
// rtl/keypad_matrix_emulator.sv - 4x4 membrane keypad model driven by a column scanner
module keypad_matrix_emulator
  import keypad_pkg::*;
#(
  parameter int BOUNCE_LEN    = 2000,
  parameter int BOUNCE_PERIOD = 250,
  parameter int GAP_LEN       = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        C0,
  input  logic        C1,
  output logic        F0,
  output logic        F1,
  output logic        F2,
  output logic        F3,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_key,
  input  logic [23:0] req_hold,
  output logic        busy,
  output logic        done,
  output logic        contact
);

  localparam int GW = $clog2(GAP_LEN + 1);
  localparam logic [GW-1:0] G_LAST = GW'(GAP_LEN - 1);
  localparam bit HAS_BOUNCE = (BOUNCE_LEN > 0);

  state_t        state;
  state_t        state_nxt;
  key_t          key_q;
  logic [23:0]   hold_last;
  logic [23:0]   hold_cnt;
  logic [GW-1:0] gap_cnt;
  logic          live;
  logic [NUM_ROWS-1:0] f_q;
  logic          accept;
  logic          b_last;
  logic          hold_end;
  logic          gap_end;
  logic          gen_start;
  logic          gen_active;

  assign accept   = req_valid && req_ready;
  assign hold_end = (state == HOLD) && (hold_cnt == hold_last);
  assign gap_end  = (state == GAP) && (gap_cnt == G_LAST);

  // Next-state selection for the press sequence
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (accept)   state_nxt = HAS_BOUNCE ? BOUNCE_IN : HOLD;
      BOUNCE_IN:  if (b_last)   state_nxt = HOLD;
      HOLD:       if (hold_end) state_nxt = HAS_BOUNCE ? BOUNCE_OUT : GAP;
      BOUNCE_OUT: if (b_last)   state_nxt = GAP;
      GAP:        if (gap_end)  state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // State register; live keeps req_ready low until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      live  <= 1'b0;
    end else begin
      state <= state_nxt;
      live  <= 1'b1;
    end
  end

  // Request latch: key and hold length are captured only on acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q     <= '0;
      hold_last <= '0;
    end else if (accept) begin
      key_q     <= req_key;
      hold_last <= (req_hold == 24'd0) ? 24'd0 : req_hold - 24'd1;
    end
  end

  // Hold and gap duration counters run from zero on state entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
      gap_cnt  <= '0;
    end else begin
      hold_cnt <= (state == HOLD) ? hold_cnt + 24'd1 : 24'd0;
      gap_cnt  <= (state == GAP) ? gap_cnt + 1'b1 : '0;
    end
  end

  // done lands on the first IDLE cycle after the gap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done <= 1'b0;
    end else begin
      done <= gap_end;
    end
  end

  assign gen_start  = ((state_nxt == BOUNCE_IN) && (state != BOUNCE_IN)) ||
                      ((state_nxt == BOUNCE_OUT) && (state != BOUNCE_OUT));
  assign gen_active = (state == BOUNCE_IN) || (state == BOUNCE_OUT);

  keypad_contact_gen #(
    .BOUNCE_LEN    (BOUNCE_LEN),
    .BOUNCE_PERIOD (BOUNCE_PERIOD)
  ) u_contact_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (gen_start),
    .active  (gen_active),
    .phase   (state == BOUNCE_IN),
    .level   (state == HOLD),
    .contact (contact),
    .last    (b_last)
  );

  // Registered row drive: only the pressed key's row goes low while its column is scanned
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_q <= '1;
    end else begin
      for (int i = 0; i < NUM_ROWS; i++) begin
        f_q[i] <= ~(contact && (key_row(key_q) == 2'(i)) && ({C1, C0} == key_col(key_q)));
      end
    end
  end

  assign {F3, F2, F1, F0} = f_q;
  assign req_ready = live && (state == IDLE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_keypad_matrix_emulator.sv
// tb/tb_keypad_matrix_emulator.sv - directed self-checking bench for keypad_matrix_emulator
module tb_keypad_matrix_emulator;

  localparam int BP = 2;
  localparam int GL = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        c0, c1;
  logic        rv0, rv1;
  logic [3:0]  req_key;
  logic [23:0] req_hold;
  logic [3:0]  u0_f, u1_f;
  logic        u0_ready, u1_ready, u0_busy, u1_busy, u0_done, u1_done, u0_contact, u1_contact;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  keypad_matrix_emulator #(.BOUNCE_LEN(8), .BOUNCE_PERIOD(BP), .GAP_LEN(GL)) u0 (
    .clk(clk), .rst_n(rst_n), .C0(c0), .C1(c1),
    .F0(u0_f[0]), .F1(u0_f[1]), .F2(u0_f[2]), .F3(u0_f[3]),
    .req_valid(rv0), .req_ready(u0_ready), .req_key(req_key), .req_hold(req_hold),
    .busy(u0_busy), .done(u0_done), .contact(u0_contact)
  );

  keypad_matrix_emulator #(.BOUNCE_LEN(0), .BOUNCE_PERIOD(BP), .GAP_LEN(GL)) u1 (
    .clk(clk), .rst_n(rst_n), .C0(c0), .C1(c1),
    .F0(u1_f[0]), .F1(u1_f[1]), .F2(u1_f[2]), .F3(u1_f[3]),
    .req_valid(rv1), .req_ready(u1_ready), .req_key(req_key), .req_hold(req_hold),
    .busy(u1_busy), .done(u1_done), .contact(u1_contact)
  );

  task automatic check(input string tag, input int k, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  // Expected contact in the k-th cycle after acceptance (k=1 is the first busy cycle)
  function automatic bit exp_contact(input int k, input int h, input int bl);
    int o;
    if (k < 1) return 1'b0;
    o = k - 1;
    if (o < bl) return ((o / BP) % 2) == 0;
    o -= bl;
    if (o < h) return 1'b1;
    o -= h;
    if (o < bl) return ((o / BP) % 2) == 1;
    return 1'b0;
  endfunction

  task automatic seq(input bit sel, input logic [3:0] key, input logic [23:0] hold,
                     input bit cyc, input bit keep);
    int h, bl, len;
    logic [1:0] col, pcol;
    bit pcon, ec;
    logic [3:0] ef;
    h   = (hold == 24'd0) ? 1 : int'(hold);
    bl  = sel ? 0 : 8;
    len = 2 * bl + h + GL;
    req_key  = key;
    req_hold = hold;
    if (sel) rv1 = 1'b1; else rv0 = 1'b1;
    col = cyc ? 2'd0 : key[1:0];
    {c1, c0} = col;
    check("ready_at_accept", 0, sel ? u1_ready : u0_ready, 4'd1);
    pcol = col;
    pcon = 1'b0;
    for (int k = 1; k <= len + 1; k++) begin
      @(posedge clk);
      #1;
      if (!keep) begin
        rv0 = 1'b0;
        rv1 = 1'b0;
      end
      ec = exp_contact(k, h, bl);
      ef = 4'hF;
      if (pcon && pcol == key[1:0]) ef[key[3:2]] = 1'b0;
      check("contact", k, sel ? u1_contact : u0_contact, ec);
      check("rows", k, sel ? u1_f : u0_f, ef);
      check("busy", k, sel ? u1_busy : u0_busy, (k <= len) ? 4'd1 : 4'd0);
      check("done", k, sel ? u1_done : u0_done, (k == len + 1) ? 4'd1 : 4'd0);
      check("ready", k, sel ? u1_ready : u0_ready, (k == len + 1) ? 4'd1 : 4'd0);
      col = cyc ? 2'(k % 4) : key[1:0];
      {c1, c0} = col;
      pcol = col;
      pcon = ec;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    {c1, c0} = 2'b00;
    rv0 = 1'b0;
    rv1 = 1'b0;
    req_key = 4'd0;
    req_hold = 24'd0;
    #12;
    check("rst_rows", 0, u0_f, 4'hF);
    check("rst_ready", 0, u0_ready, 4'd0);
    check("rst_busy", 0, u0_busy, 4'd0);
    check("rst_done", 0, u0_done, 4'd0);
    check("rst_contact", 0, u0_contact, 4'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_rst", 0, u0_ready, 4'd1);
    check("ready_after_rst_b0", 0, u1_ready, 4'd1);

    // Key 9 with column fixed at 01: full bounce/hold/bounce/gap sequence, done at T+31
    seq(1'b0, 4'b1001, 24'd10, 1'b0, 1'b0);
    // Same press with the scanner cycling columns every clock
    seq(1'b0, 4'b1001, 24'd10, 1'b1, 1'b0);
    // Zero hold behaves as one cycle, done at T+22
    seq(1'b0, 4'b1001, 24'd0, 1'b0, 1'b0);
    // Back-to-back with req_valid held high: key 0 then key 15
    seq(1'b0, 4'b0000, 24'd3, 1'b1, 1'b1);
    seq(1'b0, 4'b1111, 24'd5, 1'b1, 1'b1);
    rv0 = 1'b0;
    // Clean-edge build: no bounce, done at T+1+hold+gap
    seq(1'b1, 4'b0110, 24'd5, 1'b0, 1'b0);

    // Reset asserted mid-HOLD
    req_key  = 4'b1001;
    req_hold = 24'd10;
    {c1, c0} = 2'b01;
    rv0 = 1'b1;
    @(posedge clk);
    #1;
    rv0 = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    check("mid_hold_contact", 12, u0_contact, 4'd1);
    check("mid_hold_rows", 12, u0_f, 4'b1011);
    rst_n = 1'b0;
    #1;
    check("async_rst_rows", 12, u0_f, 4'hF);
    check("async_rst_busy", 12, u0_busy, 4'd0);
    check("async_rst_contact", 12, u0_contact, 4'd0);
    check("async_rst_ready", 12, u0_ready, 4'd0);
    @(posedge clk);
    #1;
    check("in_rst_rows", 13, u0_f, 4'hF);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_ready", 14, u0_ready, 4'd1);
    for (int k = 14; k < 18; k++) begin
      check("post_rst_done", k, u0_done, 4'd0);
      check("post_rst_busy", k, u0_busy, 4'd0);
      check("post_rst_rows", k, u0_f, 4'hF);
      @(posedge clk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
